// File: rtl/ifmap_stream_buf.sv
// Ifmap plane buffer: loads N_CH planes by address, then streams them as
// {last,type,dst,col,data} packets in raster order for a number of passes.
module ifmap_stream_buf #(
    parameter int          WIDTH_DATA = 13,
    parameter int          DEPTH_I    = 25,
    parameter int          WIDTH_I    = 25,
    parameter int          DEPTH_R    = 21,
    parameter int          N_CH       = 1,
    parameter logic [1:0]  DATA_TYPE  = 2'b01,
    localparam int         PLANE      = DEPTH_I * WIDTH_I,
    localparam int         ADDR_W     = $clog2(PLANE),
    localparam int         CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int         PKT_W      = 19 + WIDTH_DATA
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [CH_W-1:0]       wr_ch,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [WIDTH_DATA-1:0] wr_data,
    input  logic                  start,
    input  logic [3:0]            passes,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PKT_W-1:0]      out_pkt,
    output logic                  load_done,
    output logic                  done,
    output logic                  addr_err
);

    localparam int TOTAL = N_CH * PLANE;
    localparam int TOT_W = $clog2(TOTAL + 1);
    localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int ROW_W = (DEPTH_I > 1) ? $clog2(DEPTH_I) : 1;
    localparam int COL_W = (WIDTH_I > 1) ? $clog2(WIDTH_I) : 1;

    localparam logic [ADDR_W:0]  PLANE_V  = (ADDR_W + 1)'(PLANE);
    localparam logic [CH_W:0]    N_CH_V   = (CH_W + 1)'(N_CH);
    localparam logic [TOT_W-1:0] CNT_LAST = TOT_W'(TOTAL - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DEPTH_I - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH_I - 1);

    typedef enum logic [1:0] {LOAD, LOADED, STREAM} state_t;

    state_t state, state_n;

    // Not reset: contents survive a return to LOAD and a reset.
    logic [WIDTH_DATA-1:0] mem [TOTAL];

    logic [TOT_W-1:0] wr_cnt;
    logic [IDX_W-1:0] rd_ptr;
    logic [IDX_W-1:0] wr_idx;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [3:0]       pass_cnt, pass_max;
    logic             wr_acc, in_range, wr_ok, wr_last;
    logic             hs, pkt_last, final_hs;
    logic [7:0]       dst;

    assign wr_ready  = (state == LOAD);
    assign load_done = (state == LOADED);
    assign out_valid = (state == STREAM);

    assign wr_acc   = wr_valid && wr_ready;
    assign in_range = ({1'b0, wr_addr} < PLANE_V) && ({1'b0, wr_ch} < N_CH_V);
    assign wr_ok    = wr_acc && in_range;
    assign wr_last  = wr_ok && (wr_cnt == CNT_LAST);
    assign wr_idx   = IDX_W'(int'(wr_ch) * PLANE + int'(wr_addr));

    assign hs       = out_valid && out_ready;
    assign pkt_last = (row == ROW_LAST) && (col == COL_LAST);
    assign final_hs = hs && pkt_last && (rd_ptr == IDX_LAST) && (pass_cnt == pass_max - 4'd1);

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= LOAD;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            LOAD:    if (wr_last)  state_n = LOADED;
            LOADED:  if (start)    state_n = STREAM;
            STREAM:  if (final_hs) state_n = LOAD;
            default:               state_n = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt   <= '0;
            rd_ptr   <= '0;
            row      <= '0;
            col      <= '0;
            pass_cnt <= '0;
            pass_max <= '0;
            done     <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            done <= final_hs;
            if (wr_acc && !in_range)
                addr_err <= 1'b1;
            if (wr_ok)
                wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;

            if (state == LOADED && start) begin
                pass_max <= (passes == 4'd0) ? 4'd1 : passes;
                pass_cnt <= '0;
                rd_ptr   <= '0;
                row      <= '0;
                col      <= '0;
            end else if (hs) begin
                // Raster walk; rd_ptr spans all channel planes back to back.
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (rd_ptr == IDX_LAST) begin
                    rd_ptr   <= '0;
                    pass_cnt <= final_hs ? 4'd0 : pass_cnt + 4'd1;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // Rows beyond the PE array fold onto the last PE row with a 3-bit offset.
    always_comb begin
        if (int'(row) < DEPTH_R)
            dst = {5'(row), 3'b000};
        else
            dst = {5'(DEPTH_R - 1), 3'(int'(row) - (DEPTH_R - 1))};
    end

    assign out_pkt = out_valid ? {pkt_last, DATA_TYPE, dst, 8'(col), mem[rd_ptr]} : '0;

endmodule

// File: tb/tb_ifmap_stream_buf.sv
// Scoreboard bench for ifmap_stream_buf: stimulus pushes expected packets,
// a negedge monitor pops and compares on every output handshake.
module tb_ifmap_stream_buf;

    localparam int PLANE = 625;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid, wr_ready;
    logic [0:0]  wr_ch;
    logic [9:0]  wr_addr;
    logic [12:0] wr_data;
    logic        start;
    logic [3:0]  passes;
    logic        out_valid, out_ready;
    logic [31:0] out_pkt;
    logic        load_done, done, addr_err;

    int          n_chk = 0, n_err = 0;
    int          done_cnt = 0, last_cnt = 0, hs_total = 0;
    logic [31:0] sb[$];
    logic [31:0] got_q[$];
    int          model_mem[PLANE];
    logic        rand_rdy = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] stall_pkt;

    always #5 clk = ~clk;

    ifmap_stream_buf dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .passes(passes),
        .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt),
        .load_done(load_done), .done(done), .addr_err(addr_err)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_pkt(input int r, input int c, input int d);
        logic [7:0] dst;
        logic       last;
        if (r < 21) dst = 8'(r * 8);
        else        dst = 8'(20 * 8 + (r - 20));
        last = (r == 24 && c == 24);
        return {last, 2'b01, dst, 8'(c), 13'(d)};
    endfunction

    task automatic push_stream(input int p);
        for (int k = 0; k < p; k++)
            for (int r = 0; r < 25; r++)
                for (int c = 0; c < 25; c++)
                    sb.push_back(exp_pkt(r, c, model_mem[r * 25 + c]));
    endtask

    task automatic wr(input int ch, input int a, input int d);
        wr_valid = 1'b1;
        wr_ch    = 1'(ch);
        wr_addr  = 10'(a);
        wr_data  = 13'(d);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        if (a < PLANE && ch < 1) model_mem[a] = d;
    endtask

    task automatic run_stream(input int p, input int n, input int nlast, input bit full_rate);
        int d0, l0, cyc;
        d0 = done_cnt;
        l0 = last_cnt;
        got_q.delete();
        push_stream((p == 0) ? 1 : p);
        rand_rdy = !full_rate;
        start  = 1'b1;
        passes = 4'(p);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (done) break;
        end
        chk("done_seen", 32'(done), 32'd1);
        if (full_rate) chk("throughput_cycles", cyc, n + 1);
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt - d0, 1);
        chk("last_count", last_cnt - l0, nlast);
        chk("pkt_count", got_q.size(), n);
        chk("sb_empty", sb.size(), 0);
        chk("out_valid_after", 32'(out_valid), 32'd0);
        chk("load_done_after", 32'(load_done), 32'd0);
        chk("wr_ready_after", 32'(wr_ready), 32'd1);
        rand_rdy = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("stall_hold_pkt", out_pkt, stall_pkt);
                chk("stall_hold_valid", 32'(out_valid), 32'd1);
            end
            stall     = out_valid && !out_ready;
            stall_pkt = out_pkt;
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                hs_total++;
                got_q.push_back(out_pkt);
                if (out_pkt[31]) last_cnt++;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_pkt: got %h expected none", out_pkt);
                end else begin
                    chk("pkt", out_pkt, sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] t;
        int h0, cyc, d0;
        wr_valid = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
        start = 1'b0; passes = '0;
        for (int i = 0; i < PLANE; i++) model_mem[i] = 0;

        repeat (3) @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pkt", out_pkt, 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);

        start = 1'b1; passes = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("start_in_load_valid", 32'(out_valid), 32'd0);
        chk("start_in_load_ready", 32'(wr_ready), 32'd1);

        wr(0, 700, 5);
        chk("addr_err_addr", 32'(addr_err), 32'd1);
        wr(1, 3, 5);
        chk("addr_err_ch", 32'(addr_err), 32'd1);
        for (int a = 0; a < 624; a++) wr(0, a, a);
        chk("load_done_early", 32'(load_done), 32'd0);
        chk("wr_ready_early", 32'(wr_ready), 32'd1);
        wr(0, 624, 624);
        chk("load_done_set", 32'(load_done), 32'd1);
        chk("wr_ready_loaded", 32'(wr_ready), 32'd0);

        run_stream(1, 625, 1, 1'b0);
        if (got_q.size() > 550) begin
            chk("first_pkt", got_q[0], 32'h2000_0000);
            t = got_q[550];
            chk("row22_dst", 32'(t[28:21]), 32'hA2);
        end

        // Duplicate write counts toward completion; addr 623 keeps old data.
        wr(0, 10, 13'h1FFF);
        wr(0, 624, 7);
        for (int a = 0; a < 623; a++) wr(0, a, a);
        chk("load_done_dup", 32'(load_done), 32'd1);
        run_stream(3, 1875, 3, 1'b1);
        if (got_q.size() > 624) begin
            chk("dup_overwrite", got_q[10], 32'h2001_400A);
            chk("row24_col24", got_q[624], 32'hB483_0007);
        end

        for (int a = 0; a < PLANE; a++) wr(0, a, 624 - a);
        run_stream(0, 625, 1, 1'b0);

        for (int a = 0; a < PLANE; a++) wr(0, a, a);
        push_stream(1);
        h0 = hs_total;
        start = 1'b1; passes = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (hs_total - h0 < 100 && cyc < 5000) begin
            @(posedge clk);
            cyc++;
        end
        chk("hs_wait", 32'(hs_total - h0 >= 100), 32'd1);
        #1;
        rst_n = 1'b0;
        sb.delete();
        d0 = done_cnt;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_pkt", out_pkt, 32'd0);
        chk("midrst_load_done", 32'(load_done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_wr_ready", 32'(wr_ready), 32'd1);
        chk("midrst_addr_err", 32'(addr_err), 32'd0);
        repeat (20) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_idle", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
